imem_loader: RTL and testbench

Byte-stream programmer for the single-cycle core's instruction memory: accepts a length-prefixed stream of bytes over a valid/ready handshake, assembles little-endian 32-bit words, and issues one write per word into the instruction memory write port. Holds the CPU while a load is in progress, so the core fetches only after the image is complete. Sits between the host/debug byte source and the instruction memory, as the write end of the instruction-memory interface.

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_loader.sv | 143 ++++++++++++++
 tb/tb_imem_loader.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Constants shared between the instruction-memory loader and the
//               instruction memory itself: memory geometry and the loader's
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

   // Instruction memory geometry (words of 32 bits)
   localparam int IMEM_DEPTH_WORDS = 2048;
   localparam int IMEM_ADDR_W      = 11;

   // Loader state encoding
   localparam int STATE_W = 2;
   typedef logic [STATE_W-1:0] ldr_state_t;

   localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [STATE_W-1:0] ST_RECV  = 2'd1;
   localparam logic [STATE_W-1:0] ST_WRITE = 2'd2;
   localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Byte-stream programmer for the instruction memory. Accepts a
//               length-prefixed stream of bytes over valid/ready, assembles
//               little-endian 32-bit words and writes one word per WRITE cycle.
//               The CPU is held while a load is in progress.
// Revision    : 1.0 - initial release
//
// Ports
//   i_clk         clock, rising edge
//   i_reset       asynchronous, active-low reset
//   i_start       one-cycle load request (honoured only in IDLE)
//   i_num_words   number of words to load, sampled with an accepted i_start
//   i_byte_valid  source presents a byte on i_byte_data
//   i_byte_data   stream byte
//   o_byte_ready  loader accepts a byte this cycle
//   o_we          instruction memory write strobe
//   o_waddr       word-aligned byte address of the write
//   o_wdata       assembled word
//   o_busy        load in progress
//   o_cpu_hold    keep the core held while high
//   o_done        one-cycle pulse after the final word write
//   o_err         sticky: last i_start carried an illegal count
//   o_checksum    XOR of all words written in the current/last load
// ============================================================================
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
   parameter int ADDR_W      = IMEM_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [ADDR_W:0]   i_num_words,
   input  logic              i_byte_valid,
   input  logic [7:0]        i_byte_data,
   output logic              o_byte_ready,
   output logic              o_we,
   output logic [31:0]       o_waddr,
   output logic [31:0]       o_wdata,
   output logic              o_busy,
   output logic              o_cpu_hold,
   output logic              o_done,
   output logic              o_err,
   output logic [31:0]       o_checksum
);

   localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W+1)'(DEPTH_WORDS);

   ldr_state_t        state;
   logic [ADDR_W:0]   count;
   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        byte_idx;
   logic [31:0]       word;
   logic [31:0]       checksum;
   logic              err;

   logic              count_legal;
   logic              byte_fire;
   logic              last_word;

   // Illegal counts (0 or larger than the memory) never leave IDLE, so the
   // word index can never run past DEPTH_WORDS-1.
   assign count_legal = (i_num_words != '0) && (i_num_words <= MAX_COUNT);

   // Ready is a pure decode of the registered state, so no input reaches an
   // output combinationally.
   assign byte_fire   = i_byte_valid && (state == ST_RECV);
   assign last_word   = ({1'b0, word_idx} == (count - 1'b1));

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state    <= ST_IDLE;
         count    <= '0;
         word_idx <= '0;
         byte_idx <= '0;
         word     <= '0;
         checksum <= '0;
         err      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  if (count_legal) begin
                     count    <= i_num_words;
                     word_idx <= '0;
                     byte_idx <= '0;
                     checksum <= '0;
                     err      <= 1'b0;
                     state    <= ST_RECV;
                  end else begin
                     err      <= 1'b1;
                  end
               end
            end

            ST_RECV: begin
               if (byte_fire) begin
                  // Little-endian: byte k lands in bits [8k+7:8k]
                  word[8*byte_idx +: 8] <= i_byte_data;
                  byte_idx              <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     state <= ST_WRITE;
                  end
               end
            end

            ST_WRITE: begin
               checksum <= checksum ^ word;
               byte_idx <= '0;
               if (last_word) begin
                  state <= ST_DONE;
               end else begin
                  word_idx <= word_idx + 1'b1;
                  state    <= ST_RECV;
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_byte_ready = (state == ST_RECV);
   assign o_we         = (state == ST_WRITE);
   assign o_done       = (state == ST_DONE);
   assign o_busy       = (state != ST_IDLE);
   assign o_cpu_hold   = (state != ST_IDLE);
   assign o_waddr      = {{(32-ADDR_W-2){1'b0}}, word_idx, 2'b00};
   assign o_wdata      = word;
   assign o_err        = err;
   assign o_checksum   = checksum;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [11:0] num_words;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        we;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic        busy;
   logic        cpu_hold;
   logic        done;
   logic        err;
   logic [31:0] checksum;

   imem_loader dut (
      .i_clk        (clk),
      .i_reset      (rst_n),
      .i_start      (start),
      .i_num_words  (num_words),
      .i_byte_valid (byte_valid),
      .i_byte_data  (byte_data),
      .o_byte_ready (byte_ready),
      .o_we         (we),
      .o_waddr      (waddr),
      .o_wdata      (wdata),
      .o_busy       (busy),
      .o_cpu_hold   (cpu_hold),
      .o_done       (done),
      .o_err        (err),
      .o_checksum   (checksum)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned cyc      = 0;
   logic [31:0] wq_addr[$];
   logic [31:0] wq_data[$];
   logic        in_load  = 1'b0;
   int          hold_low = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor: record every memory write, and any cycle of a load in
   // which the CPU hold is missing.
   always @(negedge clk) begin
      if (we) begin
         wq_addr.push_back(waddr);
         wq_data.push_back(wdata);
      end
      if (in_load && !cpu_hold) hold_low++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // All tasks begin and end at a falling edge.
   task automatic do_start(input logic [11:0] n);
      start     = 1'b1;
      num_words = n;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok = 1'b0;
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      for (int t = 0; t < 50; t++) begin
         if (byte_ready) begin
            ok = 1'b1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      byte_valid = 1'b0;
      if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int k = 0; k < 4; k++)
         send_byte(w[8*k +: 8], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
   endtask

   // Returns at the falling edge where o_done is seen.
   task automatic wait_done(output int unsigned dcyc);
      bit ok = 1'b0;
      dcyc = 0;
      for (int t = 0; t < 200; t++) begin
         if (done) begin
            ok   = 1'b1;
            dcyc = cyc;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   logic [31:0] words3[3];
   logic [31:0] exp_sum;
   int unsigned s_cyc;
   int unsigned d_cyc;
   int          ready_seen;

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      num_words  = '0;
      byte_valid = 1'b0;
      byte_data  = '0;

      // ---------------- Reset with random inputs ----------------
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         start      = 1'($urandom_range(0, 1));
         num_words  = 12'($urandom_range(0, 4095));
         byte_valid = 1'($urandom_range(0, 1));
         byte_data  = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      check("rst_ready",    {31'd0, byte_ready}, 32'd0);
      check("rst_we",       {31'd0, we},         32'd0);
      check("rst_waddr",    waddr,               32'd0);
      check("rst_wdata",    wdata,               32'd0);
      check("rst_busy",     {31'd0, busy},       32'd0);
      check("rst_hold",     {31'd0, cpu_hold},   32'd0);
      check("rst_done",     {31'd0, done},       32'd0);
      check("rst_err",      {31'd0, err},        32'd0);
      check("rst_checksum", checksum,            32'd0);
      check("rst_no_write", 32'(wq_addr.size()), 32'd0);
      start      = 1'b0;
      byte_valid = 1'b0;
      num_words  = '0;
      rst_n      = 1'b1;
      @(negedge clk);

      // ---------------- One word, no stalls ----------------
      s_cyc = cyc;
      do_start(12'd1);
      check("w1_ready_after_start", {31'd0, byte_ready}, 32'd1);
      check("w1_busy",              {31'd0, busy},       32'd1);
      send_word(32'h0000_0013, 0);
      wait_done(d_cyc);
      check("w1_latency", d_cyc - s_cyc, 32'd6);
      @(negedge clk);
      check("w1_done_one_cycle", {31'd0, done}, 32'd0);
      check("w1_idle_after",     {31'd0, busy}, 32'd0);
      check("w1_n_writes", 32'(wq_addr.size()), 32'd1);
      if (wq_addr.size() > 0) begin
         check("w1_addr", wq_addr[0], 32'h0);
         check("w1_data", wq_data[0], 32'h0000_0013);
      end
      check("w1_checksum", checksum, 32'h0000_0013);

      // ---------------- Three words with random gaps ----------------
      wq_addr.delete();
      wq_data.delete();
      words3[0] = 32'h0050_0093;
      words3[1] = 32'h0010_0113;
      words3[2] = 32'h0020_81B3;
      exp_sum   = words3[0] ^ words3[1] ^ words3[2];
      hold_low  = 0;
      do_start(12'd3);
      in_load = 1'b1;
      for (int w = 0; w < 3; w++) send_word(words3[w], 3);
      wait_done(d_cyc);
      in_load = 1'b0;
      check("w3_hold_during_load", 32'(hold_low), 32'd0);
      @(negedge clk);
      check("w3_hold_released", {31'd0, cpu_hold}, 32'd0);
      check("w3_n_writes", 32'(wq_addr.size()), 32'd3);
      for (int w = 0; w < 3 && w < wq_addr.size(); w++) begin
         check($sformatf("w3_addr%0d", w), wq_addr[w], 32'(w * 4));
         check($sformatf("w3_data%0d", w), wq_data[w], words3[w]);
      end
      check("w3_checksum", checksum, exp_sum);

      // ---------------- Illegal counts ----------------
      wq_addr.delete();
      wq_data.delete();
      do_start(12'd0);
      check("ill0_err",  {31'd0, err},  32'd1);
      check("ill0_busy", {31'd0, busy}, 32'd0);
      do_start(12'd2049);
      check("ill2049_err", {31'd0, err}, 32'd1);
      ready_seen = 0;
      byte_valid = 1'b1;
      byte_data  = 8'hA5;
      for (int i = 0; i < 4; i++) begin
         if (byte_ready) ready_seen++;
         @(negedge clk);
      end
      byte_valid = 1'b0;
      check("ill_ready_low", 32'(ready_seen), 32'd0);
      check("ill_no_write",  32'(wq_addr.size()), 32'd0);
      check("ill_checksum_kept", checksum, exp_sum);
      do_start(12'd2048);
      check("max_count_err_clear", {31'd0, err},  32'd1 - 32'd1);
      check("max_count_busy",      {31'd0, busy}, 32'd1);
      pulse_reset();
      check("abort_idle", {31'd0, busy}, 32'd0);

      // ---------------- Reset mid-word ----------------
      wq_addr.delete();
      wq_data.delete();
      do_start(12'd2);
      send_word(32'h1122_3344, 0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy",  {31'd0, busy},       32'd0);
      check("mid_rst_hold",  {31'd0, cpu_hold},   32'd0);
      check("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_n_writes", 32'(wq_addr.size()), 32'd1);
      wq_addr.delete();
      wq_data.delete();
      do_start(12'd1);
      send_word(32'hDEAD_BEEF, 1);
      wait_done(d_cyc);
      @(negedge clk);
      check("reload_n_writes", 32'(wq_addr.size()), 32'd1);
      if (wq_addr.size() > 0) begin
         check("reload_addr", wq_addr[0], 32'h0);
         check("reload_data", wq_data[0], 32'hDEAD_BEEF);
      end
      check("reload_checksum", checksum, 32'hDEAD_BEEF);

      // ---------------- i_start during RECV ignored ----------------
      wq_addr.delete();
      wq_data.delete();
      do_start(12'd2);
      send_byte(8'h01, 0);
      start     = 1'b1;
      num_words = 12'd5;
      @(negedge clk);
      start     = 1'b0;
      send_byte(8'h02, 0);
      send_byte(8'h03, 0);
      send_byte(8'h04, 0);
      send_word(32'hCAFE_0001, 0);
      wait_done(d_cyc);
      @(negedge clk);
      check("ign_n_writes", 32'(wq_addr.size()), 32'd2);
      if (wq_addr.size() > 1) begin
         check("ign_data0", wq_data[0], 32'h0403_0201);
         check("ign_addr1", wq_addr[1], 32'h4);
      end
      check("ign_checksum", checksum, 32'h0403_0201 ^ 32'hCAFE_0001);
      check("ign_idle",     {31'd0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_imem_loader
`default_nettype wire
